// File: rtl/fmsg_pkg.sv
// Shared definitions for the fmsg arbiter: packet field layout, urgent
// TYPE code and the output-register state encoding.
package fmsg_pkg;

  localparam int FMSG_W   = 8;
  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 6;
  localparam int DEST_MSB = 5;
  localparam int DEST_LSB = 4;
  localparam int PAY_MSB  = 3;
  localparam int PAY_LSB  = 0;

  localparam logic [1:0] TYPE_URGENT = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // True when the packet carries the urgent TYPE code.
  function automatic logic is_urgent(input logic [FMSG_W-1:0] fmsg);
    return fmsg[TYPE_MSB:TYPE_LSB] == TYPE_URGENT;
  endfunction

endpackage

// File: rtl/fmsg_decoder.sv
// Splits a raw fmsg byte into its TYPE, DEST and PAYLOAD fields.
module fmsg_decoder
  import fmsg_pkg::*;
(
  input  logic [FMSG_W-1:0] i_fmsg,
  output logic [1:0]        o_type,
  output logic [1:0]        o_dest,
  output logic [3:0]        o_payload
);

  assign o_type    = i_fmsg[TYPE_MSB:TYPE_LSB];
  assign o_dest    = i_fmsg[DEST_MSB:DEST_LSB];
  assign o_payload = i_fmsg[PAY_MSB:PAY_LSB];

endmodule

// File: rtl/fmsg_rr_pick.sv
// Combinational round-robin picker. Urgent requesters form the candidate
// set whenever any exist; the first candidate after i_ptr wins.
module fmsg_rr_pick #(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [N_SRC-1:0] i_urgent,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [N_SRC-1:0] o_grant,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any
);

  logic [N_SRC-1:0] w_urg_req;
  logic [N_SRC-1:0] w_cand;
  logic [SRC_W-1:0] w_scan;

  assign w_urg_req = i_req & i_urgent;
  assign w_cand    = (|w_urg_req) ? w_urg_req : i_req;

  // Scan ptr+1 .. ptr+N_SRC (mod N_SRC) and keep the first candidate hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_scan  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_scan = SRC_W'((int'(i_ptr) + k) % N_SRC);
      if (!o_any && w_cand[w_scan]) begin
        o_any           = 1'b1;
        o_grant[w_scan] = 1'b1;
        o_idx           = w_scan;
      end
    end
  end

endmodule

// File: rtl/fmsg_arbiter.sv
// N-way fmsg arbiter: urgent-first round-robin grant into a one-entry
// output register, with a stall watchdog that discards packets a dead
// consumer never takes.
module fmsg_arbiter
  import fmsg_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 255,
  parameter int SRC_W   = $clog2(N_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [8*N_SRC-1:0]    src_fmsg,
  output logic [N_SRC-1:0]      src_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_fmsg,
  output logic [1:0]            out_type,
  output logic [1:0]            out_dest,
  output logic [3:0]            out_payload,
  output logic [SRC_W-1:0]      out_src,
  output logic                  drop_pulse,
  output logic [7:0]            drop_cnt
);

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [FMSG_W-1:0]   r_fmsg;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_ptr;
  logic [15:0]         r_stall;
  logic                r_drop_pulse;
  logic [7:0]          r_drop_cnt;

  logic [FMSG_W-1:0]   w_pkt [N_SRC];
  logic [N_SRC-1:0]    w_urgent;
  logic [N_SRC-1:0]    w_grant;
  logic [SRC_W-1:0]    w_idx;
  logic                w_any;
  logic                w_full;
  logic                w_handshake;
  logic                w_drop;
  logic                w_load_en;
  logic                w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign w_pkt[gi]    = src_fmsg[FMSG_W*gi +: FMSG_W];
      assign w_urgent[gi] = is_urgent(w_pkt[gi]);
    end
  endgenerate

  fmsg_rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .i_req    (src_valid),
    .i_urgent (w_urgent),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // A timed-out packet frees the register in the same cycle, so a waiting
  // source can be loaded without an extra bubble.
  assign w_full      = (r_state == FULL);
  assign w_handshake = w_full && out_ready;
  assign w_drop      = w_full && !out_ready && (r_stall == STALL_LIMIT);
  assign w_load_en   = !w_full || w_handshake || w_drop;
  assign w_accept    = w_load_en && w_any;
  assign src_ready   = w_grant & {N_SRC{w_load_en}};

  // Next state: a new accept fills the register, any other release empties it.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = FULL;
    end else if (w_load_en) begin
      w_state_next = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the granted packet and move the round-robin pointer to the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fmsg <= '0;
      r_src  <= '0;
      r_ptr  <= SRC_W'(N_SRC - 1);
    end else if (w_accept) begin
      r_fmsg <= w_pkt[w_idx];
      r_src  <= w_idx;
      r_ptr  <= w_idx;
    end
  end

  // Stall counter runs only while a held packet is refused; drop count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall      <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_stall      <= w_load_en ? 16'd0 : r_stall + 16'd1;
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  fmsg_decoder u_dec (
    .i_fmsg    (r_fmsg),
    .o_type    (out_type),
    .o_dest    (out_dest),
    .o_payload (out_payload)
  );

  assign out_valid  = w_full;
  assign out_fmsg   = r_fmsg;
  assign out_src    = r_src;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fmsg_arbiter.sv
// Bench for fmsg_arbiter: two instances (TIMEOUT 255 and 4) share one
// stimulus stream and are each tracked by a behavioural reference model.
module tb_fmsg_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_fmsg = '0;
  logic        out_ready = 1'b0;

  logic [3:0] a_src_ready, b_src_ready;
  logic       a_out_valid, b_out_valid;
  logic [7:0] a_out_fmsg, b_out_fmsg;
  logic [1:0] a_out_type, b_out_type;
  logic [1:0] a_out_dest, b_out_dest;
  logic [3:0] a_out_payload, b_out_payload;
  logic [1:0] a_out_src, b_out_src;
  logic       a_drop_pulse, b_drop_pulse;
  logic [7:0] a_drop_cnt, b_drop_cnt;

  always #5 clk = ~clk;

  fmsg_arbiter #(.N_SRC(N), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_fmsg(src_fmsg),
    .src_ready(a_src_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_fmsg(a_out_fmsg), .out_type(a_out_type), .out_dest(a_out_dest),
    .out_payload(a_out_payload), .out_src(a_out_src),
    .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt)
  );

  fmsg_arbiter #(.N_SRC(N), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_fmsg(src_fmsg),
    .src_ready(b_src_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_fmsg(b_out_fmsg), .out_type(b_out_type), .out_dest(b_out_dest),
    .out_payload(b_out_payload), .out_src(b_out_src),
    .drop_pulse(b_drop_pulse), .drop_cnt(b_drop_cnt)
  );

  // Reference model: what the output register holds and how long it waited.
  typedef struct {
    bit         full;
    logic [7:0] pkt;
    int         src;
    int         last;   // source granted most recently
    int         waited; // cycles the held packet has been refused
    bit         pulse;
    int         cnt;
  } mdl_t;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] f;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [7:0]  exp_fm;
    logic [1:0]  exp_src;
  } vec_t;

  mdl_t ma, mb;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.full = 0; m.pkt = 8'h00; m.src = 0; m.last = N - 1;
    m.waited = 0; m.pulse = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic bit mdl_free(mdl_t m, bit rdy, int to);
    return !m.full || rdy || (m.waited == to - 1);
  endfunction

  // Winner = smallest rank; urgent packets rank below every non-urgent one,
  // ties broken by distance after the last granted source.
  function automatic int mdl_pick(mdl_t m, logic [3:0] v, logic [31:0] f, bit free);
    int best, best_rank, rank;
    best = -1;
    best_rank = 1000;
    if (!free) return -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        rank = (i - m.last - 1 + 2 * N) % N;
        if (f[8*i+6 +: 2] != 2'b11) rank = rank + N;
        if (rank < best_rank) begin
          best_rank = rank;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, logic [3:0] v, logic [31:0] f, bit rdy, int to);
    mdl_t n;
    bit   drop, free;
    int   w;
    n = m;
    drop = m.full && !rdy && (m.waited == to - 1);
    free = mdl_free(m, rdy, to);
    w = mdl_pick(m, v, f, free);
    n.pulse = drop;
    if (drop && n.cnt < 255) n.cnt = n.cnt + 1;
    if (w >= 0) begin
      n.full = 1; n.pkt = f[8*w +: 8]; n.src = w; n.last = w; n.waited = 0;
    end else if (free) begin
      n.full = 0; n.waited = 0;
    end else begin
      n.waited = n.waited + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag, input mdl_t m, input int to,
                           input logic [3:0] rdy_o, input logic ov, input logic [7:0] fm,
                           input logic [1:0] ty, input logic [1:0] de, input logic [3:0] pa,
                           input logic [1:0] so, input logic dp, input logic [7:0] dc);
    int w;
    w = mdl_pick(m, src_valid, src_fmsg, mdl_free(m, out_ready, to));
    chk({tag, ".src_ready"}, 32'(rdy_o), (w >= 0) ? (32'd1 << w) : 32'd0);
    chk({tag, ".out_valid"}, 32'(ov), 32'(m.full));
    chk({tag, ".out_fmsg"}, 32'(fm), 32'(m.pkt));
    chk({tag, ".out_type"}, 32'(ty), 32'(m.pkt[7:6]));
    chk({tag, ".out_dest"}, 32'(de), 32'(m.pkt[5:4]));
    chk({tag, ".out_payload"}, 32'(pa), 32'(m.pkt[3:0]));
    chk({tag, ".out_src"}, 32'(so), 32'(m.src));
    chk({tag, ".drop_pulse"}, 32'(dp), 32'(m.pulse));
    chk({tag, ".drop_cnt"}, 32'(dc), 32'(m.cnt));
  endtask

  // Let inputs settle, then compare both instances against their models.
  task automatic settle();
    #1;
    cmp_model("A", ma, 255, a_src_ready, a_out_valid, a_out_fmsg, a_out_type,
              a_out_dest, a_out_payload, a_out_src, a_drop_pulse, a_drop_cnt);
    cmp_model("B", mb, 4, b_src_ready, b_out_valid, b_out_fmsg, b_out_type,
              b_out_dest, b_out_payload, b_out_src, b_drop_pulse, b_drop_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    ma = mdl_next(ma, src_valid, src_fmsg, out_ready, 255);
    mb = mdl_next(mb, src_valid, src_fmsg, out_ready, 4);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{4'b0010, 32'h00006F00, 1'b0, 4'b0010, 1'b1, 8'h6F, 2'd1};
    tbl[1]  = '{4'b1000, 32'h2B000000, 1'b1, 4'b1000, 1'b1, 8'h2B, 2'd3};
    tbl[2]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h2B, 2'd3};
    tbl[3]  = '{4'b1111, 32'h04030201, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0};
    tbl[4]  = '{4'b1111, 32'h04030201, 1'b1, 4'b0010, 1'b1, 8'h02, 2'd1};
    tbl[5]  = '{4'b1111, 32'h04030201, 1'b1, 4'b0100, 1'b1, 8'h03, 2'd2};
    tbl[6]  = '{4'b1111, 32'h04030201, 1'b1, 4'b1000, 1'b1, 8'h04, 2'd3};
    tbl[7]  = '{4'b1111, 32'h04030201, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0};
    tbl[8]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h01, 2'd0};
    tbl[9]  = '{4'b1101, 32'hC11A001A, 1'b1, 4'b1000, 1'b1, 8'hC1, 2'd3};
    tbl[10] = '{4'b0101, 32'hC11A001A, 1'b1, 4'b0001, 1'b1, 8'h1A, 2'd0};
    tbl[11] = '{4'b0100, 32'hC11A001A, 1'b1, 4'b0100, 1'b1, 8'h1A, 2'd2};
    tbl[12] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h1A, 2'd2};

    // Reset state.
    do_reset();
    #1;
    chk("reset.out_valid", 32'(a_out_valid), 32'd0);
    chk("reset.out_fmsg", 32'(a_out_fmsg), 32'd0);
    chk("reset.out_src", 32'(a_out_src), 32'd0);
    chk("reset.drop_pulse", 32'(a_drop_pulse), 32'd0);
    chk("reset.drop_cnt", 32'(a_drop_cnt), 32'd0);

    // Table: single source, round-robin order, urgent precedence.
    for (int r = 0; r < 13; r++) begin
      src_valid = tbl[r].v;
      src_fmsg  = tbl[r].f;
      out_ready = tbl[r].rdy;
      settle();
      chk($sformatf("vec%0d.src_ready", r), 32'(a_src_ready), 32'(tbl[r].exp_ready));
      tick();
      chk($sformatf("vec%0d.out_valid", r), 32'(a_out_valid), 32'(tbl[r].exp_ov));
      chk($sformatf("vec%0d.out_fmsg", r), 32'(a_out_fmsg), 32'(tbl[r].exp_fm));
      chk($sformatf("vec%0d.out_type", r), 32'(a_out_type), 32'(tbl[r].exp_fm[7:6]));
      chk($sformatf("vec%0d.out_dest", r), 32'(a_out_dest), 32'(tbl[r].exp_fm[5:4]));
      chk($sformatf("vec%0d.out_payload", r), 32'(a_out_payload), 32'(tbl[r].exp_fm[3:0]));
      chk($sformatf("vec%0d.out_src", r), 32'(a_out_src), 32'(tbl[r].exp_src));
      $display("[TB] vec %0d: valid=%b ready=%b -> out_valid=%b fmsg=%h src=%0d",
               r, tbl[r].v, a_src_ready, a_out_valid, a_out_fmsg, a_out_src);
    end

    // Backpressure on the TIMEOUT=255 instance.
    do_reset();
    src_valid = 4'b0100; src_fmsg = 32'h00950000; out_ready = 1'b0;
    settle(); tick();
    src_valid = 4'b1011; src_fmsg = 32'h44950201;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp.src_ready", 32'(a_src_ready), 32'd0);
      chk("bp.out_fmsg", 32'(a_out_fmsg), 32'h95);
      chk("bp.out_valid", 32'(a_out_valid), 32'd1);
      chk("bp.drop_pulse", 32'(a_drop_pulse), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    settle();
    chk("bp.release_ready", 32'(a_src_ready), 32'h8);
    tick();
    chk("bp.after_fmsg", 32'(a_out_fmsg), 32'h44);
    chk("bp.after_drop_pulse", 32'(a_drop_pulse), 32'd0);
    chk("bp.after_drop_cnt", 32'(a_drop_cnt), 32'd0);
    $display("[TB] backpressure: held 95 for 5 cycles, then handed off");

    // Watchdog on the TIMEOUT=4 instance, with a source waiting at the drop.
    do_reset();
    src_valid = 4'b0001; src_fmsg = 32'h00000025; out_ready = 1'b0;
    settle(); tick();
    src_valid = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      if (t == 3) begin
        src_valid = 4'b0010; src_fmsg = 32'h00003C00;
      end
      settle();
      chk($sformatf("wd.t%0d.src_ready", t), 32'(b_src_ready), (t == 3) ? 32'h2 : 32'h0);
      chk($sformatf("wd.t%0d.drop_pulse", t), 32'(b_drop_pulse), 32'd0);
      tick();
    end
    src_valid = 4'b0000;
    settle();
    chk("wd.drop_pulse", 32'(b_drop_pulse), 32'd1);
    chk("wd.drop_cnt", 32'(b_drop_cnt), 32'd1);
    chk("wd.reload_valid", 32'(b_out_valid), 32'd1);
    chk("wd.reload_fmsg", 32'(b_out_fmsg), 32'h3C);
    chk("wd.reload_src", 32'(b_out_src), 32'd1);
    tick();
    settle();
    chk("wd.pulse_one_cycle", 32'(b_drop_pulse), 32'd0);
    $display("[TB] watchdog: packet 25 dropped, 3C loaded in the drop cycle");

    // Forced drops until the counter saturates.
    src_valid = 4'b1111; src_fmsg = 32'h04030201; out_ready = 1'b0;
    for (int c = 0; c < 1250; c++) begin
      settle(); tick();
    end
    settle();
    chk("sat.drop_cnt", 32'(b_drop_cnt), 32'd255);
    $display("[TB] saturation: drop_cnt=%0d after forced drops", b_drop_cnt);

    // Randomized traffic; every fourth block stalls the consumer outright.
    for (int blk = 0; blk < 12; blk++) begin
      for (int c = 0; c < 300; c++) begin
        src_valid = 4'($urandom_range(0, 15));
        src_fmsg  = $urandom;
        out_ready = (blk % 4 == 3) ? 1'b0 : ($urandom_range(0, 4) != 0);
        settle(); tick();
      end
      $display("[TB] random block %0d done, failures so far %0d", blk, n_fail);
    end

    // Asynchronous reset while both instances hold a stalled packet.
    src_valid = 4'b0001; src_fmsg = 32'h000000AB; out_ready = 1'b0;
    settle(); tick();
    src_valid = 4'b0000;
    settle(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.a_out_valid", 32'(a_out_valid), 32'd0);
    chk("arst.b_out_valid", 32'(b_out_valid), 32'd0);
    chk("arst.a_out_fmsg", 32'(a_out_fmsg), 32'd0);
    chk("arst.a_drop_cnt", 32'(a_drop_cnt), 32'd0);
    chk("arst.b_drop_cnt", 32'(b_drop_cnt), 32'd0);
    chk("arst.a_drop_pulse", 32'(a_drop_pulse), 32'd0);
    chk("arst.b_drop_pulse", 32'(b_drop_pulse), 32'd0);
    ma = mdl_reset();
    mb = mdl_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_valid = 4'b1111; src_fmsg = 32'h04030201; out_ready = 1'b1;
    settle();
    chk("arst.first_grant", 32'(a_src_ready), 32'h1);
    tick();
    chk("arst.first_src", 32'(a_out_src), 32'd0);
    chk("arst.first_fmsg", 32'(a_out_fmsg), 32'h01);
    $display("[TB] async reset: cleared mid-packet, source 0 granted first");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
